// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between a load/store requester and dmem_responder
// req_be exists only when DMEM_BYTE_WRITE_EN is defined.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0]  req_be;
`endif
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

`ifdef DMEM_BYTE_WRITE_EN
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
`else
    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
`endif
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder with response backpressure
// Optional byte-enable stores via DMEM_BYTE_WRITE_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0]      be_q, be_d;
`endif
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     mem_rd;
    logic            accept;
    logic            addr_bad;
    logic            commit;

    assign accept   = bus.req_valid && (state_q == ST_IDLE);
    assign addr_bad = (bus.req_addr[1:0] != 2'b00) ||
                      (bus.req_addr[31:2] >= 30'(DEPTH_WORDS));
    // The counter runs WAIT_CYCLES..0, so commit lands WAIT_CYCLES+1 edges after acceptance.
    assign commit   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign mem_rd   = mem[addr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
`ifdef DMEM_BYTE_WRITE_EN
            be_q    <= 4'd0;
`endif
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef DMEM_BYTE_WRITE_EN
            be_q    <= be_d;
`endif
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef DMEM_BYTE_WRITE_EN
        be_d    = be_q;
`endif
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr[AW+1:2];
                    wdata_d = bus.req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
                    be_d    = bus.req_be;
`endif
                    if (addr_bad) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = wr_q ? 32'd0 : mem_rd;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.resp_valid = (state_q == ST_RESP);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
    end

    // RAM has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (commit && wr_q) begin
`ifdef DMEM_BYTE_WRITE_EN
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
`else
            mem[addr_q] <= wdata_q;
`endif
        end
    end
endmodule
